// File: rtl/fc_seq_ctrl.sv
// fc_seq_ctrl: flow-control FSM for a single-MAC fully connected layer.
// It loads an M-word input vector, then computes N dot products one row at a
// time. Each result is handed downstream with valid/ready before the next row starts.
module fc_seq_ctrl #(
  parameter int M       = 4,
  parameter int N       = 4,
  parameter int MAC_LAT = 1,
  parameter int XA      = $clog2(M),
  parameter int WA      = $clog2(M*N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          input_valid,
  output logic          input_ready,
  output logic          output_valid,
  input  logic          output_ready,
  output logic [XA-1:0] addr_x,
  output logic          wr_en_x,
  output logic [WA-1:0] addr_w,
  output logic          clear_acc,
  output logic          en_acc
);

  localparam int RW = (N > 1) ? $clog2(N) : 1;
  localparam int LW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

  localparam logic [XA-1:0] XMAX = XA'(M - 1);
  localparam logic [RW-1:0] RMAX = RW'(N - 1);
  localparam logic [LW-1:0] LMAX = LW'(MAC_LAT - 1);

  localparam logic [1:0] S_LOAD = 2'd0;
  localparam logic [1:0] S_COMP = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_OUT  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [XA-1:0] ld_q, ld_d;      // words loaded so far
  logic [XA-1:0] col_q, col_d;    // column being issued
  logic [RW-1:0] row_q, row_d;    // current output row
  logic [WA-1:0] base_q, base_d;  // row*M, kept incrementally to avoid a multiplier
  logic [LW-1:0] lat_q, lat_d;    // cycles spent in WAIT
  logic          issue_q;         // issue strobe delayed by the memory read latency
  logic          in_hs;
  logic [XA-1:0] col_eff;

  // Input handshake: only LOAD accepts words, and nothing is accepted while reset is high
  assign input_ready  = (state_q == S_LOAD) && !reset;
  assign in_hs        = input_valid && input_ready;
  assign wr_en_x      = in_hs;
  assign output_valid = (state_q == S_OUT);
  assign clear_acc    = (state_q == S_COMP) && (col_q == '0);
  assign en_acc       = issue_q;

  // Address mux: after the last column, hold that column's address through WAIT and OUTPUT
  always_comb begin
    col_eff = XMAX;
    addr_x  = XMAX;
    case (state_q)
      S_LOAD: begin
        col_eff = '0;
        addr_x  = ld_q;
      end
      S_COMP: begin
        col_eff = col_q;
        addr_x  = col_q;
      end
      default: ;
    endcase
    addr_w = base_q + WA'(col_eff);
  end

  // Next-state and counter logic
  always_comb begin
    state_d = state_q;
    ld_d    = ld_q;
    col_d   = col_q;
    row_d   = row_q;
    base_d  = base_q;
    lat_d   = lat_q;
    case (state_q)
      S_LOAD: begin
        if (in_hs) begin
          if (ld_q == XMAX) begin
            ld_d    = '0;
            col_d   = '0;
            row_d   = '0;
            base_d  = '0;
            state_d = S_COMP;
          end else begin
            ld_d = ld_q + XA'(1);
          end
        end
      end
      S_COMP: begin
        if (col_q == XMAX) begin
          col_d   = '0;
          lat_d   = '0;
          state_d = S_WAIT;
        end else begin
          col_d = col_q + XA'(1);
        end
      end
      S_WAIT: begin
        if (lat_q == LMAX) state_d = S_OUT;
        else               lat_d   = lat_q + LW'(1);
      end
      default: begin
        if (output_ready) begin
          if (row_q == RMAX) begin
            row_d   = '0;
            base_d  = '0;
            state_d = S_LOAD;
          end else begin
            row_d   = row_q + RW'(1);
            base_d  = base_q + WA'(M);
            state_d = S_COMP;
          end
        end
      end
    endcase
  end

  // State registers; reset discards any partial vector or row and flushes the issue pipe
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_LOAD;
      ld_q    <= '0;
      col_q   <= '0;
      row_q   <= '0;
      base_q  <= '0;
      lat_q   <= '0;
      issue_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ld_q    <= ld_d;
      col_q   <= col_d;
      row_q   <= row_d;
      base_q  <= base_d;
      lat_q   <= lat_d;
      issue_q <= (state_q == S_COMP);
    end
  end

endmodule

// File: tb/tb_fc_seq_ctrl.sv
// Directed and randomized check of fc_seq_ctrl with a small behavioural
// datapath: input memory, weight ROM w[i]=i+1, and a MAC with latency 1.
module tb_fc_seq_ctrl;
  localparam int M = 4;
  localparam int N = 4;
  localparam int XA = $clog2(M);
  localparam int WA = $clog2(M*N);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          input_valid = 1'b0;
  logic          output_ready = 1'b0;
  logic          input_ready, output_valid, wr_en_x, clear_acc, en_acc;
  logic [XA-1:0] addr_x;
  logic [WA-1:0] addr_w;

  int n_chk = 0;
  int n_err = 0;

  logic [7:0]  input_data = '0;
  logic [7:0]  xmem [M];
  logic [7:0]  xrd, wrd;
  logic [31:0] acc;
  logic [7:0]  vin [M];

  fc_seq_ctrl #(.M(M), .N(N), .MAC_LAT(1)) dut (
    .clk(clk), .reset(reset),
    .input_valid(input_valid), .input_ready(input_ready),
    .output_valid(output_valid), .output_ready(output_ready),
    .addr_x(addr_x), .wr_en_x(wr_en_x), .addr_w(addr_w),
    .clear_acc(clear_acc), .en_acc(en_acc)
  );

  always #5 clk = ~clk;

  // Behavioural datapath: 1-cycle memory reads, accumulator updates at the edge
  always_ff @(posedge clk) begin
    if (wr_en_x) xmem[addr_x] <= input_data;
    xrd <= xmem[addr_x];
    wrd <= 8'(addr_w) + 8'd1;
    if (clear_acc)   acc <= '0;
    else if (en_acc) acc <= acc + 32'(xrd) * 32'(wrd);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Streams vin[] in with valid held high; assumes the controller is in LOAD
  task automatic load_vec(input bit do_chk);
    for (int i = 0; i < M; i++) begin
      input_valid = 1'b1;
      input_data  = vin[i];
      @(negedge clk);
      if (do_chk) begin
        chk($sformatf("ld_addr%0d", i), 32'(addr_x), 32'(i));
        chk($sformatf("ld_we%0d", i), 32'(wr_en_x), 32'd1);
      end
      step();
    end
    input_valid = 1'b0;
  endtask

  task automatic wait_out(input string tag, input logic [31:0] exp);
    int n = 0;
    @(negedge clk);
    while (!output_valid && n < 50) begin
      step();
      @(negedge clk);
      n++;
    end
    if (!output_valid) chk({tag, "_timeout"}, 32'd0, 32'd1);
    else               chk(tag, acc, exp);
    step();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int out_cnt, vidx, widx, viol;
    bit hold;
    logic [31:0] q[$];
    logic [7:0]  cur [M];
    logic [31:0] s;

    // 1: reset state
    step(); step();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_ir", 32'(input_ready), 32'd1);
    chk("rst_ov", 32'(output_valid), 32'd0);
    chk("rst_we", 32'(wr_en_x), 32'd0);
    chk("rst_en", 32'(en_acc), 32'd0);
    chk("rst_clr", 32'(clear_acc), 32'd0);
    step();

    // 2: continuous load of 1,2,3,4
    vin = '{8'd1, 8'd2, 8'd3, 8'd4};
    output_ready = 1'b1;
    load_vec(1'b1);

    // 3: row 0 timing; result 1*1+2*2+3*3+4*4 = 30
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      if (t == 0) chk("c0_ir", 32'(input_ready), 32'd0);
      chk($sformatf("r0_aw%0d", t), 32'(addr_w), 32'((t < 4) ? t : 3));
      chk($sformatf("r0_clr%0d", t), 32'(clear_acc), 32'(t == 0));
      chk($sformatf("r0_en%0d", t), 32'(en_acc), 32'(t >= 1 && t <= 4));
      chk($sformatf("r0_ov%0d", t), 32'(output_valid), 32'(t == 5));
      if (t == 5) chk("r0_acc", acc, 32'd30);
      step();
    end

    // 4: downstream stalls row 1 for 10 cycles; result 70
    output_ready = 1'b0;
    repeat (5) step();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk($sformatf("st_ov%0d", k), 32'(output_valid), 32'd1);
      chk($sformatf("st_en%0d", k), 32'(en_acc), 32'd0);
      chk($sformatf("st_clr%0d", k), 32'(clear_acc), 32'd0);
      chk($sformatf("st_aw%0d", k), 32'(addr_w), 32'd7);
      step();
    end
    output_ready = 1'b1;
    @(negedge clk);
    chk("r1_ov", 32'(output_valid), 32'd1);
    chk("r1_acc", acc, 32'd70);
    step();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("r2_aw%0d", c), 32'(addr_w), 32'(8 + c));
      step();
    end
    step();
    @(negedge clk);
    chk("r2_acc", acc, 32'd110);
    step();
    repeat (5) step();
    @(negedge clk);
    chk("r3_ov", 32'(output_valid), 32'd1);
    chk("r3_acc", acc, 32'd150);
    step();
    @(negedge clk);
    chk("post_ir", 32'(input_ready), 32'd1);
    chk("post_ov", 32'(output_valid), 32'd0);
    step();

    // 6: reset during row 2, column 1, then a fresh vector 5,6,7,8
    vin = '{8'd1, 8'd2, 8'd3, 8'd4};
    load_vec(1'b0);
    repeat (13) step();
    @(negedge clk);
    chk("mid_aw", 32'(addr_w), 32'd9);
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("mid_ir", 32'(input_ready), 32'd1);
    chk("mid_ov", 32'(output_valid), 32'd0);
    chk("mid_en", 32'(en_acc), 32'd0);
    chk("mid_clr", 32'(clear_acc), 32'd0);
    step();
    vin = '{8'd5, 8'd6, 8'd7, 8'd8};
    load_vec(1'b0);
    wait_out("fr_y0", 32'd70);
    wait_out("fr_y1", 32'd174);
    wait_out("fr_y2", 32'd278);
    wait_out("fr_y3", 32'd382);

    // 5: random valid/ready over 100 vectors against a golden dot-product model
    out_cnt = 0; vidx = 0; widx = 0; viol = 0; hold = 1'b0;
    for (int c = 0; c < M; c++) cur[c] = 8'($urandom_range(0, 255));
    for (int cyc = 0; cyc < 40000 && out_cnt < 4 * 100; cyc++) begin
      input_valid  = (vidx < 100) ? 1'($urandom_range(0, 1)) : 1'b0;
      input_data   = cur[widx];
      output_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (input_ready && (output_valid || en_acc || clear_acc)) viol++;
      if (hold && !output_valid) viol++;
      hold = output_valid && !output_ready;
      if (input_valid && input_ready) begin
        widx++;
        if (widx == M) begin
          for (int r = 0; r < N; r++) begin
            s = 0;
            for (int c = 0; c < M; c++) s += 32'(cur[c]) * 32'(r * M + c + 1);
            q.push_back(s);
          end
          widx = 0;
          vidx++;
          for (int c = 0; c < M; c++) cur[c] = 8'($urandom_range(0, 255));
        end
      end
      if (output_valid && output_ready) begin
        if (q.size() == 0) chk("sb_extra", 32'd1, 32'd0);
        else               chk($sformatf("rnd_y%0d", out_cnt), acc, q.pop_front());
        out_cnt++;
      end
      step();
    end
    input_valid  = 1'b0;
    output_ready = 1'b0;
    chk("rnd_nout", 32'(out_cnt), 32'd400);
    chk("rnd_nvec", 32'(vidx), 32'd100);
    chk("rnd_proto", 32'(viol), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
